// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the single write port of a downstream FIFO; tracks occupancy itself.
// Optional FIFO_ARB_ALMOST_FULL_EN adds almost_full and reserves the headroom above AF_LEVEL for requester 0.
module fifo_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*DW-1:0]         req_data,
    input  logic                       fifo_r_en,
    output logic [NREQ-1:0]            gnt,
    output logic                       fifo_w_en,
    output logic [DW-1:0]              fifo_d_in,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
`ifdef FIFO_ARB_ALMOST_FULL_EN
    output logic                       almost_full,
`endif
    output logic                       o_dbg_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef FIFO_ARB_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
`endif

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic [NREQ-1:0] r_gnt;
    logic [DW-1:0]   r_d_in;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [PW-1:0]   w_win;
    logic            w_rd;

    // Eligibility is judged on the registered count only; a same-cycle read never frees a slot early.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req[i] && (r_count < DEPTH_C);
`ifdef FIFO_ARB_ALMOST_FULL_EN
            if (i != 0) w_elig[i] = req[i] && (r_count < AF_C);
`endif
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = int'(r_ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && w_elig[PW'(idx)]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_rd = fifo_r_en && (r_count != '0);

    always_comb begin
        w_state_next = IDLE;
        if (w_found) w_state_next = GRANT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_d_in  <= '0;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_gnt <= '0;
            if (w_found) begin
                r_gnt[w_win] <= 1'b1;
                r_d_in       <= req_data[int'(w_win)*DW +: DW];
                r_ptr        <= (w_win == PW'(NREQ-1)) ? '0 : w_win + 1'b1;
            end
            case ({w_found, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign fifo_w_en   = (r_state == GRANT);
    assign fifo_d_in   = r_d_in;
    assign count       = r_count;
    assign full        = (r_count == DEPTH_C);
    assign empty       = (r_count == '0);
    assign o_dbg_state = r_state;
`ifdef FIFO_ARB_ALMOST_FULL_EN
    assign almost_full = (r_count >= AF_C);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic        fifo_r_en = 1'b0;
    logic [3:0]  gnt;
    logic        fifo_w_en;
    logic [7:0]  fifo_d_in;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        o_dbg_state;
`ifdef FIFO_ARB_ALMOST_FULL_EN
    logic        almost_full;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_ptr   = 0;
    int         m_count = 0;
    logic [3:0] m_gnt   = '0;
    logic       m_wen   = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(4), .DW(8), .DEPTH(16), .AF_LEVEL(12)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_r_en(fifo_r_en),
        .gnt(gnt), .fifo_w_en(fifo_w_en), .fifo_d_in(fifo_d_in), .count(count),
        .full(full), .empty(empty),
`ifdef FIFO_ARB_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .o_dbg_state(o_dbg_state)
    );

    task automatic model_clear();
        m_ptr = 0; m_count = 0; m_gnt = '0; m_wen = 1'b0;
        exp_q.delete();
    endtask

    // Drives one cycle of inputs and advances the model to what the DUT should show after the edge.
    task automatic drive_cycle(input logic [3:0] r, input logic [31:0] d, input logic ren);
        int  w;
        bit  ok;
        bit  rd;
        logic [7:0] dv;
        @(negedge clk);
        req = r; req_data = d; fifo_r_en = ren;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            int i;
            i  = (m_ptr + k) % 4;
            ok = r[i] && (m_count < 16);
`ifdef FIFO_ARB_ALMOST_FULL_EN
            if (i != 0) ok = r[i] && (m_count < 12);
`endif
            if (ok && w < 0) w = i;
        end
        rd = ren && (m_count > 0);
        if (w >= 0) m_count = m_count + 1;
        if (rd)     m_count = m_count - 1;
        if (w >= 0) begin
            m_gnt = 4'b0001 << w;
            m_wen = 1'b1;
            dv    = d[w*8 +: 8];
            exp_q.push_back(dv);
            m_ptr = (w + 1) % 4;
        end else begin
            m_gnt = '0;
            m_wen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; fifo_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) drive_cycle(4'hf, $urandom, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks += 5;
        if (gnt !== 4'b0000)    begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", fifo_w_en); end
        if (count !== 5'd0)     begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [8];
        logic [7:0] e;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive_cycle(4'hf, $urandom, 1'b0);
            n_checks += 3;
            if (gnt !== seq[c])   begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, seq[c]); end
            if (fifo_w_en !== 1'b1) begin n_fail++; $display("FAIL rr_wen[%0d]: got %b expected 1", c, fifo_w_en); end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            if (fifo_d_in !== e)  begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", c, fifo_d_in, e); end
        end
        n_checks++;
        if (count !== 5'd8) begin n_fail++; $display("FAIL rr_count: got %0d expected 8", count); end
    endtask

    task automatic test_single();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'b0100, $urandom, 1'b0);
            n_checks++;
            if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b expected 0100", c, gnt); end
        end
        drive_cycle(4'b0101, $urandom, 1'b0);
        n_checks += 2;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_wrap: got %b expected 0001", gnt); end
        if (count !== 5'd4)  begin n_fail++; $display("FAIL single_count: got %0d expected 4", count); end
    endtask

    task automatic test_full();
        int ngr;
        ngr = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive_cycle(4'b0001, $urandom, 1'b0);
            if (gnt[0]) ngr++;
            n_checks++;
            if (gnt !== m_gnt) begin n_fail++; $display("FAIL full_gnt[%0d]: got %b expected %b", c, gnt, m_gnt); end
        end
        n_checks += 3;
        if (ngr != 16)       begin n_fail++; $display("FAIL full_grants: got %0d expected 16", ngr); end
        if (full !== 1'b1)   begin n_fail++; $display("FAIL full_flag: got %b expected 1", full); end
        if (count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", count); end
        drive_cycle(4'b0000, 32'h0, 1'b1);
        n_checks += 2;
        if (count !== 5'd15) begin n_fail++; $display("FAIL full_read_count: got %0d expected 15", count); end
        if (full !== 1'b0)   begin n_fail++; $display("FAIL full_read_flag: got %b expected 0", full); end
        drive_cycle(4'b0001, $urandom, 1'b0);
        n_checks += 2;
        if (gnt !== 4'b0001) begin n_fail++; $display("FAIL full_regrant: got %b expected 0001", gnt); end
        if (count !== 5'd16) begin n_fail++; $display("FAIL full_refill: got %0d expected 16", count); end
        drive_cycle(4'b0001, $urandom, 1'b1);
        n_checks++;
        if (gnt !== 4'b0000) begin n_fail++; $display("FAIL full_block: got %b expected 0000", gnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 5; c++) drive_cycle(4'b0010, $urandom, 1'b0);
        drive_cycle(4'b0010, $urandom, 1'b1);
        n_checks += 2;
        if (gnt !== 4'b0010) begin n_fail++; $display("FAIL simul_gnt: got %b expected 0010", gnt); end
        if (count !== 5'd5)  begin n_fail++; $display("FAIL simul_count: got %0d expected 5", count); end
        for (int c = 0; c < 5; c++) begin
            drive_cycle(4'b0000, 32'h0, 1'b1);
            n_checks++;
            if (count !== 5'(m_count)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", c, count, m_count); end
        end
        drive_cycle(4'b0000, 32'h0, 1'b1);
        n_checks += 2;
        if (count !== 5'd0) begin n_fail++; $display("FAIL underflow_count: got %0d expected 0", count); end
        if (empty !== 1'b1) begin n_fail++; $display("FAIL underflow_empty: got %b expected 1", empty); end
    endtask

    task automatic test_random();
        logic [7:0] e;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive_cycle(4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 99) < ((c < 200) ? 20 : 75)));
            n_checks += 6;
            if (gnt !== m_gnt)            begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, m_gnt); end
            if (fifo_w_en !== m_wen)      begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b expected %b", c, fifo_w_en, m_wen); end
            if (o_dbg_state !== m_wen)    begin n_fail++; $display("FAIL rnd_state[%0d]: got %b expected %b", c, o_dbg_state, m_wen); end
            if (count !== 5'(m_count))    begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, count, m_count); end
            if (full !== (m_count == 16)) begin n_fail++; $display("FAIL rnd_full[%0d]: got %b expected %b", c, full, m_count == 16); end
            if (empty !== (m_count == 0)) begin n_fail++; $display("FAIL rnd_empty[%0d]: got %b expected %b", c, empty, m_count == 0); end
`ifdef FIFO_ARB_ALMOST_FULL_EN
            n_checks++;
            if (almost_full !== (m_count >= 12)) begin n_fail++; $display("FAIL rnd_af[%0d]: got %b", c, almost_full); end
`endif
            if (fifo_w_en === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_checks++;
                if (fifo_d_in !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, fifo_d_in, e); end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_missing_writes: got %0d left expected 0", exp_q.size()); end
    endtask

`ifdef FIFO_ARB_ALMOST_FULL_EN
    task automatic test_almost_full();
        do_reset();
        for (int c = 0; c < 12; c++) drive_cycle(4'b0001, $urandom, 1'b0);
        drive_cycle(4'b1110, $urandom, 1'b0);
        n_checks += 3;
        if (gnt !== 4'b0000)     begin n_fail++; $display("FAIL af_block: got %b expected 0000", gnt); end
        if (almost_full !== 1'b1) begin n_fail++; $display("FAIL af_flag: got %b expected 1", almost_full); end
        if (count !== 5'd12)     begin n_fail++; $display("FAIL af_count: got %0d expected 12", count); end
        for (int c = 0; c < 4; c++) begin
            drive_cycle(4'b0001, $urandom, 1'b0);
            n_checks++;
            if (gnt !== 4'b0001) begin n_fail++; $display("FAIL af_req0[%0d]: got %b expected 0001", c, gnt); end
        end
        n_checks++;
        if (count !== 5'd16) begin n_fail++; $display("FAIL af_final_count: got %0d expected 16", count); end
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_full();
        test_simultaneous();
`ifdef FIFO_ARB_ALMOST_FULL_EN
        test_almost_full();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
